// File: rtl/cla_pkg.sv
// -----------------------------------------------------------------------------
// cla_pkg
// Shared definitions for the nibble-serial CLA sequencer and its 4-bit slice.
//   NIB_W       : width of one CLA slice (one nibble)
//   SLICE_LAT   : cycles from driving slice inputs to its registered result
//   cla_state_e : sequencer states
//   cla_result_cycle() : cycle (acceptance = cycle 0) in which the result
//                        becomes valid, for a given nibble count
// -----------------------------------------------------------------------------
package cla_pkg;

    localparam int NIB_W     = 4;
    localparam int SLICE_LAT = 2;

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        ISSUE = 3'd1,
        WAIT  = 3'd2,
        LAST  = 3'd3,
        DONE  = 3'd4
    } cla_state_e;

    // Each nibble spends SLICE_LAT cycles in ISSUE/WAIT, then LAST adds one
    // cycle and the registered out_valid one more.
    function automatic int unsigned cla_result_cycle(input int unsigned nib);
        return nib * SLICE_LAT + 2;
    endfunction

endpackage

// File: rtl/CLA4bit.sv
// -----------------------------------------------------------------------------
// CLA4bit
// Registered 4-bit carry-lookahead adder slice. Inputs are registered on one
// rising edge and the sum/carry on the next, giving a 2-cycle latency. The
// slice has no reset; its owner must not sample it before it has been fed.
// Ports:
//   clk  : clock
//   a, b : nibble operands
//   cin  : carry-in
//   s    : registered nibble sum
//   cout : registered carry-out
// -----------------------------------------------------------------------------
module CLA4bit
    import cla_pkg::*;
(
    input  logic             clk,
    input  logic [NIB_W-1:0] a,
    input  logic [NIB_W-1:0] b,
    input  logic             cin,
    output logic [NIB_W-1:0] s,
    output logic             cout
);

    logic [NIB_W-1:0] a_q;
    logic [NIB_W-1:0] b_q;
    logic             cin_q;
    logic [NIB_W-1:0] g;
    logic [NIB_W-1:0] p;
    logic [NIB_W:0]   c;

    // NOTE: pure datapath registers carry no reset; the sequencer only reads
    // s/cout once valid inputs have been pushed through both stages.
    always_ff @(posedge clk) begin
        // NOTE: sequential state uses non-blocking assignment so every
        // register samples the pre-edge values regardless of statement order.
        a_q   <= a;
        b_q   <= b;
        cin_q <= cin;
    end

    // Lookahead carries computed directly from generate/propagate terms.
    always_comb begin
        // NOTE: every combinational output is assigned on every path so no
        // latch is inferred.
        g    = a_q & b_q;
        p    = a_q ^ b_q;
        c[0] = cin_q;
        c[1] = g[0] | (p[0] & cin_q);
        c[2] = g[1] | (p[1] & g[0]) | (p[1] & p[0] & cin_q);
        c[3] = g[2] | (p[2] & g[1]) | (p[2] & p[1] & g[0])
             | (p[2] & p[1] & p[0] & cin_q);
        c[4] = g[3] | (p[3] & g[2]) | (p[3] & p[2] & g[1])
             | (p[3] & p[2] & p[1] & g[0])
             | (p[3] & p[2] & p[1] & p[0] & cin_q);
    end

    always_ff @(posedge clk) begin
        s    <= p ^ c[NIB_W-1:0];
        cout <= c[NIB_W];
    end

endmodule

// File: rtl/cla_seq_ctrl.sv
// -----------------------------------------------------------------------------
// cla_seq_ctrl
// Performs a WIDTH-bit add over several cycles by feeding a single registered
// 4-bit CLA slice one nibble at a time, LS nibble first, chaining the slice
// carry-out into the next nibble's carry-in. Valid/ready on both sides; one
// operation in flight at a time.
// Optional feature: define CLA_SEQ_SUB_EN to add the in_sub port (A - B).
// Ports:
//   clk, rst             : clock, asynchronous active-high reset
//   in_valid/in_ready    : operand handshake (ready only in IDLE)
//   in_a, in_b, in_cin   : operands and carry-in, captured on acceptance
//   in_sub               : (CLA_SEQ_SUB_EN only) subtract: B' = ~B, cin = 1
//   out_valid/out_ready  : result handshake
//   out_sum, out_cout    : registered sum and carry-out of the MS nibble
//   out_ovf              : signed overflow of the effective addition
//   busy                 : high whenever the sequencer is not IDLE
// -----------------------------------------------------------------------------
module cla_seq_ctrl
    import cla_pkg::*;
#(
    parameter  int WIDTH = 16,
    localparam int NIB   = WIDTH / NIB_W
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_a,
    input  logic [WIDTH-1:0] in_b,
    input  logic             in_cin,
`ifdef CLA_SEQ_SUB_EN
    input  logic             in_sub,
`endif
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_sum,
    output logic             out_cout,
    output logic             out_ovf,
    output logic             busy
);

    localparam logic [2:0] ST_IDLE  = IDLE;
    localparam logic [2:0] ST_ISSUE = ISSUE;
    localparam logic [2:0] ST_WAIT  = WAIT;
    localparam logic [2:0] ST_LAST  = LAST;
    localparam logic [2:0] ST_DONE  = DONE;

    localparam int              CNT_W    = (NIB > 1) ? $clog2(NIB) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(NIB - 1);

    logic [2:0]                  state_q;
    logic [CNT_W-1:0]            cnt_q;
    logic [NIB-1:0][NIB_W-1:0]   a_q;
    logic [NIB-1:0][NIB_W-1:0]   b_q;
    logic                        cin_q;
`ifdef CLA_SEQ_SUB_EN
    logic                        sub_q;
`endif
    // Sum nibbles 0..NIB-2; the MS nibble goes straight from the slice to
    // out_sum in LAST.
    logic [NIB-2:0][NIB_W-1:0]   part_q;

    logic [NIB-1:0][NIB_W-1:0]   b_eff;
    logic                        cin0;
    logic [NIB_W-1:0]            slice_a;
    logic [NIB_W-1:0]            slice_b;
    logic                        slice_cin;
    logic [NIB_W-1:0]            slice_s;
    logic                        slice_cout;

    // Effective B operand and nibble-0 carry-in.
    always_comb begin
`ifdef CLA_SEQ_SUB_EN
        b_eff = sub_q ? ~b_q : b_q;
        cin0  = sub_q ? 1'b1 : cin_q;
`else
        b_eff = b_q;
        cin0  = cin_q;
`endif
    end

    // Slice inputs depend only on the counter and captured operands, so they
    // stay constant across ISSUE and WAIT of the same nibble. The slice
    // carry register still holds the previous nibble's carry throughout
    // ISSUE/WAIT because it only updates from the inputs registered in ISSUE.
    always_comb begin
        slice_a   = a_q[cnt_q];
        slice_b   = b_eff[cnt_q];
        slice_cin = (cnt_q == '0) ? cin0 : slice_cout;
    end

    CLA4bit u_slice (
        .clk  (clk),
        .a    (slice_a),
        .b    (slice_b),
        .cin  (slice_cin),
        .s    (slice_s),
        .cout (slice_cout)
    );

    assign in_ready = (state_q == ST_IDLE);
    assign busy     = (state_q != ST_IDLE);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= ST_IDLE;
            cnt_q     <= '0;
            a_q       <= '0;
            b_q       <= '0;
            cin_q     <= 1'b0;
`ifdef CLA_SEQ_SUB_EN
            sub_q     <= 1'b0;
`endif
            part_q    <= '0;
            out_valid <= 1'b0;
            out_sum   <= '0;
            out_cout  <= 1'b0;
            out_ovf   <= 1'b0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (in_valid) begin
                        a_q     <= in_a;
                        b_q     <= in_b;
                        cin_q   <= in_cin;
`ifdef CLA_SEQ_SUB_EN
                        sub_q   <= in_sub;
`endif
                        cnt_q   <= '0;
                        state_q <= ST_ISSUE;
                    end
                end

                ST_ISSUE: begin
                    // Slice now presents the previous nibble's result.
                    if (cnt_q != '0) begin
                        part_q[cnt_q - CNT_W'(1)] <= slice_s;
                    end
                    state_q <= ST_WAIT;
                end

                ST_WAIT: begin
                    if (cnt_q == CNT_LAST) begin
                        state_q <= ST_LAST;
                    end else begin
                        cnt_q   <= cnt_q + CNT_W'(1);
                        state_q <= ST_ISSUE;
                    end
                end

                ST_LAST: begin
                    out_sum   <= {slice_s, part_q};
                    out_cout  <= slice_cout;
                    out_ovf   <= (a_q[NIB-1][NIB_W-1] == b_eff[NIB-1][NIB_W-1])
                              && (slice_s[NIB_W-1] != a_q[NIB-1][NIB_W-1]);
                    out_valid <= 1'b1;
                    state_q   <= ST_DONE;
                end

                ST_DONE: begin
                    if (out_ready) begin
                        out_valid <= 1'b0;
                        state_q   <= ST_IDLE;
                    end
                end

                default: begin
                    state_q <= ST_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_cla_seq_ctrl.sv
// -----------------------------------------------------------------------------
// tb_cla_seq_ctrl
// Self-checking bench for cla_seq_ctrl (WIDTH=16). Expected results come from
// plain integer addition of the effective operands. Directed cases cover carry
// ripple, signed overflow, back-pressure, reset mid-operation and operand
// changes while busy; randomized operations follow.
// -----------------------------------------------------------------------------
module tb_cla_seq_ctrl;

    localparam int W   = 16;
    localparam int NIB = W / 4;

    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic         in_valid = 1'b0;
    logic         in_ready;
    logic [W-1:0] in_a = '0;
    logic [W-1:0] in_b = '0;
    logic         in_cin = 1'b0;
    logic         in_sub = 1'b0;
    logic         out_valid;
    logic         out_ready = 1'b0;
    logic [W-1:0] out_sum;
    logic         out_cout;
    logic         out_ovf;
    logic         busy;

    int checks   = 0;
    int failures = 0;

    always #5 clk = ~clk;

    cla_seq_ctrl #(.WIDTH(W)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_a      (in_a),
        .in_b      (in_b),
        .in_cin    (in_cin),
`ifdef CLA_SEQ_SUB_EN
        .in_sub    (in_sub),
`endif
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_sum   (out_sum),
        .out_cout  (out_cout),
        .out_ovf   (out_ovf),
        .busy      (busy)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=0x%0h exp=0x%0h", tag, got, exp);
        end
    endtask

    // Reference: A + B' + cin' as a (W+1)-bit integer sum.
    task automatic model(input logic [W-1:0] a, input logic [W-1:0] b,
                         input logic cin, input logic sub,
                         output logic [W-1:0] s, output logic c, output logic o);
        logic [W-1:0] bp;
        logic [W:0]   full;
        bp   = sub ? ~b : b;
        full = {1'b0, a} + {1'b0, bp} + {{W{1'b0}}, (sub ? 1'b1 : cin)};
        s    = full[W-1:0];
        c    = full[W];
        o    = (a[W-1] == bp[W-1]) && (s[W-1] != a[W-1]);
    endtask

    // One complete operation. hold = cycles out_ready stays low after
    // out_valid; poke = keep in_valid high and scramble inputs while busy.
    task automatic run_op(input logic [W-1:0] a, input logic [W-1:0] b,
                          input logic cin, input logic sub,
                          input int hold, input bit poke);
        logic [W-1:0] es;
        logic         ec;
        logic         eo;
        int           cyc;
        model(a, b, cin, sub, es, ec, eo);
        @(negedge clk);
        in_a = a; in_b = b; in_cin = cin; in_sub = sub; in_valid = 1'b1;
        check("in_ready_idle", 32'(in_ready), 32'd1);
        @(negedge clk);
        if (poke) begin
            in_a = ~a; in_b = b ^ 16'h5a5a; in_cin = ~cin; in_sub = ~sub;
        end else begin
            in_valid = 1'b0;
        end
        cyc = 1;
        check("busy_run", 32'(busy), 32'd1);
        check("in_ready_run", 32'(in_ready), 32'd0);
        while (!out_valid && cyc < 60) begin
            @(negedge clk);
            cyc++;
        end
        check("latency", 32'(cyc), 32'(2 * NIB + 2));
        check("sum", 32'(out_sum), 32'(es));
        check("cout", 32'(out_cout), 32'(ec));
        check("ovf", 32'(out_ovf), 32'(eo));
        for (int i = 0; i < hold; i++) begin
            @(negedge clk);
            check("hold_valid", 32'(out_valid), 32'd1);
            check("hold_sum", 32'(out_sum), 32'(es));
            check("hold_cout", 32'(out_cout), 32'(ec));
            check("hold_ovf", 32'(out_ovf), 32'(eo));
            check("hold_in_ready", 32'(in_ready), 32'd0);
        end
        out_ready = 1'b1;
        in_valid  = 1'b0;
        @(negedge clk);
        out_ready = 1'b0;
        check("post_valid", 32'(out_valid), 32'd0);
        check("post_in_ready", 32'(in_ready), 32'd1);
        check("post_busy", 32'(busy), 32'd0);
        check("post_sum_kept", 32'(out_sum), 32'(es));
        if (poke) begin
            for (int i = 0; i < 3; i++) begin
                @(negedge clk);
                check("single_result", 32'(out_valid), 32'd0);
                check("idle_after_poke", 32'(busy), 32'd0);
            end
        end
    endtask

    task automatic check_reset_state(input string tag);
        check({tag, "_valid"}, 32'(out_valid), 32'd0);
        check({tag, "_sum"}, 32'(out_sum), 32'd0);
        check({tag, "_cout"}, 32'(out_cout), 32'd0);
        check({tag, "_ovf"}, 32'(out_ovf), 32'd0);
        check({tag, "_busy"}, 32'(busy), 32'd0);
        check({tag, "_in_ready"}, 32'(in_ready), 32'd1);
    endtask

    initial begin
        logic [W-1:0] ra;
        logic [W-1:0] rb;
        logic         rc;
        logic         rs;

        #1;
        check_reset_state("reset");
        repeat (2) @(negedge clk);
        rst = 1'b0;

        // Carry ripples through every nibble.
        run_op(16'hFFFF, 16'h0001, 1'b0, 1'b0, 0, 1'b0);
        // Signed overflow, with 5 cycles of back-pressure.
        run_op(16'h7FFF, 16'h0001, 1'b0, 1'b0, 5, 1'b0);

        // Reset during WAIT of nibble 1 (cycle 4 after acceptance).
        @(negedge clk);
        in_a = 16'hABCD; in_b = 16'h1357; in_cin = 1'b1; in_valid = 1'b1;
        @(negedge clk);
        in_valid = 1'b0;
        repeat (3) @(negedge clk);
        rst = 1'b1;
        #1;
        check_reset_state("mid_reset");
        @(negedge clk);
        rst = 1'b0;
        run_op(16'h1234, 16'h4321, 1'b1, 1'b0, 1, 1'b0);

        // Inputs changed while busy must be ignored.
        run_op(16'h0F0F, 16'h00F1, 1'b0, 1'b0, 2, 1'b1);

`ifdef CLA_SEQ_SUB_EN
        run_op(16'h0005, 16'h0007, 1'b0, 1'b1, 0, 1'b0);
        run_op(16'h8000, 16'h0001, 1'b1, 1'b1, 1, 1'b0);
`endif

        for (int n = 0; n < 24; n++) begin
            ra = W'($urandom);
            rb = W'($urandom);
            rc = 1'($urandom_range(0, 1));
`ifdef CLA_SEQ_SUB_EN
            rs = 1'($urandom_range(0, 1));
`else
            rs = 1'b0;
`endif
            run_op(ra, rb, rc, rs, $urandom_range(0, 3), ($urandom_range(0, 3) == 0));
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
